gate_test_seq: RTL and testbench
================================

Name: gate_test_seq

Overview:
Self-checking stimulus sequencer for a small combinational logic gate (OR, AND, XOR, etc.) used on the bench and in bring-up.
- Steps the gate under test through every input combination in ascending binary order.
- Holds each vector a fixed number of cycles, samples the gate output and compares it against a parameterised truth table.
- Reports a mismatch count, the first failing vector and pass/done status.
- Sits between a test controller, which pulses start, and one gate instance.

Parameters:
- N_IN, 2, number of gate inputs (1..4).
- HOLD, 5, cycles each vector is held (>=1); the output is sampled on the last held cycle.
- TRUTH, 4'b1110, expected output per vector; bit k = expected y for input vector k (default = OR). Width 2**N_IN.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE
- gate_in  out  N_IN  vector driven to the gate inputs
- gate_out  in  1  gate output under test (combinational from gate_in)
- busy  out  1  high while a run is in progress
- done  out  1  high from the end of a run until the next start or reset
- pass  out  1  valid while done; 1 when err_count==0
- err_count  out  N_IN+1  number of mismatching vectors, range 0..2**N_IN
- first_fail  out  N_IN  lowest vector index that mismatched; 0 if none

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE; gate_in=0, busy=0, done=0, pass=0, err_count=0, first_fail=0; hold counter and vector index cleared.
  - rst overrides start.
  - Reset mid-run aborts immediately with no partial status retained.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 -> DRIVE next cycle.
  - Same edge: vector=0, hold=0, err_count=0, first_fail=0, busy=1.
- DRIVE:
  - gate_in=vector; hold increments each cycle.
  - On the cycle where hold==HOLD-1, gate_out is compared with TRUTH[vector].
  - On a mismatch, err_count increments. If this is the first mismatch of the run, first_fail=vector.
  - Same edge, if vector==2**N_IN-1: -> DONE, busy=0, done=1, pass=(final err_count==0), including any mismatch on this last vector.
  - Otherwise: vector+1, hold=0, remain in DRIVE.
- start during DRIVE is ignored.
- DONE:
  - Outputs are held stable and gate_in keeps the last vector.
  - start=1 -> DRIVE with counters cleared, exactly as from IDLE; done drops on the same edge.
- Latency: start sampled at edge E0. The first vector is driven after E0. done rises at edge E0 + (2**N_IN)*HOLD; default 20 cycles.
- err_count saturates naturally: at most 2**N_IN mismatches fit in N_IN+1 bits, so no wrap.
- gate_out is sampled only on the last held cycle; glitches earlier in the hold window are ignored.

Optional Feature:
GATE_TEST_SEQ_FAILMAP_EN
- Defined:
  - Adds output port fail_map, width 2**N_IN, reset 0.
  - fail_map is cleared on start; bit k is set when vector k mismatches; held through DONE.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package gate_test_seq_pkg:
  - State enum {IDLE, DRIVE, DONE}.
  - Truth constants TT_OR2=4'b1110, TT_AND2=4'b1000, TT_XOR2=4'b0110, TT_NOR2=4'b0001.
  - Helper function for vector count 2**N.
- One sub-module: gate_test_hold_timer.
  - Counter with clear/enable and a last-cycle flag at HOLD-1.
  - Instantiated once.

Test Plan:
- OR gate, TRUTH=TT_OR2, HOLD=5, start pulse at cycle 0:
  - gate_in steps 00, 01, 10, 11, five cycles each.
  - done=1 at cycle 20; pass=1, err_count=0, first_fail=0.
- Faulty gate model (AND wired in), TRUTH=TT_OR2:
  - Mismatches on vectors 1 and 2 give err_count=2, first_fail=2'b01, pass=0.
  - With the macro defined, fail_map=4'b0110.
- Stuck-at-1 output on vector 3 only, TRUTH=TT_XOR2:
  - err_count=1, first_fail=2'b11, pass=0.
  - Confirms the last-vector mismatch is counted before DONE.
- start pulsed again at cycles 3 and 10 during a run:
  - Ignored; done still at cycle 20.
  - A start at cycle 25 in DONE restarts: done=0 at cycle 26 and counters cleared.
- rst asserted at cycle 8 for one cycle:
  - Next cycle all outputs are 0 and state is IDLE; no run proceeds until a new start.
  - A new start then completes normally after 20 cycles.
- HOLD=1, N_IN=3, TRUTH=8'hFE (3-input OR):
  - gate_in changes every cycle 0..7; done at cycle 8; pass=1.

Source files
------------

// File: rtl/gate_test_seq_pkg.sv
// Shared types and constants for the gate_test_seq stimulus sequencer.
package gate_test_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [3:0] TT_OR2  = 4'b1110;
    localparam logic [3:0] TT_AND2 = 4'b1000;
    localparam logic [3:0] TT_XOR2 = 4'b0110;
    localparam logic [3:0] TT_NOR2 = 4'b0001;

    function automatic int vec_count(input int n);
        return 32'sd1 <<< n;
    endfunction

endpackage

// File: rtl/gate_test_seq_if.sv
// Controller/gate-side bundle for gate_test_seq; fail_map exists only with GATE_TEST_SEQ_FAILMAP_EN.
interface gate_test_seq_if
    import gate_test_seq_pkg::*;
#(
    parameter int N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] gate_in;
    logic            gate_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail;
`ifdef GATE_TEST_SEQ_FAILMAP_EN
    logic [vec_count(N_IN)-1:0] fail_map;

    modport slave  (input start, gate_out,
                    output gate_in, busy, done, pass, err_count, first_fail, fail_map);
    modport master (output start, gate_out,
                    input gate_in, busy, done, pass, err_count, first_fail, fail_map);
`else
    modport slave  (input start, gate_out,
                    output gate_in, busy, done, pass, err_count, first_fail);
    modport master (output start, gate_out,
                    input gate_in, busy, done, pass, err_count, first_fail);
`endif
endinterface

// File: rtl/gate_test_hold_timer.sv
// Per-vector hold counter; last_o marks the final held cycle (count == HOLD-1).
module gate_test_hold_timer #(
    parameter int HOLD = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);
    localparam int            CW   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign last_o = (count_q == LAST);

    // Wraps to zero on the last cycle so the next vector starts a fresh window.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = last_o ? '0 : count_q + CW'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/gate_test_seq.sv
// Exhaustive gate tester: walks all input vectors, compares against TRUTH, reports status.
// Optional fail_map output enabled by GATE_TEST_SEQ_FAILMAP_EN.
module gate_test_seq
    import gate_test_seq_pkg::*;
#(
    parameter int                         N_IN  = 2,
    parameter int                         HOLD  = 5,
    parameter logic [vec_count(N_IN)-1:0] TRUTH = 4'b1110
) (
    input  logic           clk,
    input  logic           rst,
    gate_test_seq_if.slave seq_if
);
    localparam int              NVEC    = vec_count(N_IN);
    localparam logic [N_IN-1:0] VMAX    = N_IN'(NVEC - 1);
    localparam logic [1:0]      S_IDLE  = ST_IDLE;
    localparam logic [1:0]      S_DRIVE = ST_DRIVE;
    localparam logic [1:0]      S_DONE  = ST_DONE;

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] vector_q, vector_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            last_s;
    logic            drive_s;
    logic            start_ok_s;
    logic            mismatch_s;
    logic [N_IN:0]   err_inc_s;
`ifdef GATE_TEST_SEQ_FAILMAP_EN
    logic [NVEC-1:0] map_q, map_d;
`endif

    assign drive_s    = (state_q == S_DRIVE);
    assign start_ok_s = seq_if.start && !drive_s;
    assign mismatch_s = drive_s && last_s && (seq_if.gate_out != TRUTH[vector_q]);
    assign err_inc_s  = err_q + {{N_IN{1'b0}}, mismatch_s};

    gate_test_hold_timer #(.HOLD(HOLD)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start_ok_s),
        .en_i   (drive_s),
        .last_o (last_s)
    );

    // Next-state logic; pass uses the post-increment count so a last-vector miss counts.
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        err_d    = err_q;
        ff_d     = ff_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
`ifdef GATE_TEST_SEQ_FAILMAP_EN
        map_d    = map_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok_s) begin
                    state_d  = S_DRIVE;
                    vector_d = '0;
                    err_d    = '0;
                    ff_d     = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
`ifdef GATE_TEST_SEQ_FAILMAP_EN
                    map_d    = '0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            S_DRIVE: begin
                if (last_s) begin
                    err_d = err_inc_s;
                    if (mismatch_s && (err_q == '0)) begin
                        ff_d = vector_q;
                    end else begin
                        ff_d = ff_q;
                    end
`ifdef GATE_TEST_SEQ_FAILMAP_EN
                    if (mismatch_s) begin
                        map_d[vector_q] = 1'b1;
                    end else begin
                        map_d = map_q;
                    end
`endif
                    if (vector_q == VMAX) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_inc_s == '0);
                    end else begin
                        vector_d = vector_q + N_IN'(1'b1);
                    end
                end else begin
                    state_d = S_DRIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and status registers; reset wipes any partial run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vector_q <= '0;
            err_q    <= '0;
            ff_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
`ifdef GATE_TEST_SEQ_FAILMAP_EN
            map_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            vector_q <= vector_d;
            err_q    <= err_d;
            ff_q     <= ff_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
`ifdef GATE_TEST_SEQ_FAILMAP_EN
            map_q    <= map_d;
`endif
        end
    end

    assign seq_if.gate_in    = vector_q;
    assign seq_if.busy       = busy_q;
    assign seq_if.done       = done_q;
    assign seq_if.pass       = pass_q;
    assign seq_if.err_count  = err_q;
    assign seq_if.first_fail = ff_q;
`ifdef GATE_TEST_SEQ_FAILMAP_EN
    assign seq_if.fail_map   = map_q;
`endif
endmodule

// File: tb/tb_gate_test_seq.sv
// Scoreboard bench for gate_test_seq: three instances (OR2, XOR2, OR3 with HOLD=1).
module tb_gate_test_seq;
    import gate_test_seq_pkg::*;

    typedef struct packed {
        logic [3:0] err;
        logic [2:0] ff;
        logic       pass;
        logic [7:0] map;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   kind_or = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    gate_test_seq_if #(.N_IN(2)) if_or ();
    gate_test_seq_if #(.N_IN(2)) if_xor ();
    gate_test_seq_if #(.N_IN(3)) if_or3 ();

    gate_test_seq #(.N_IN(2), .HOLD(5), .TRUTH(TT_OR2))  u_or  (.clk(clk), .rst(rst), .seq_if(if_or));
    gate_test_seq #(.N_IN(2), .HOLD(5), .TRUTH(TT_XOR2)) u_xor (.clk(clk), .rst(rst), .seq_if(if_xor));
    gate_test_seq #(.N_IN(3), .HOLD(1), .TRUTH(8'hFE))   u_or3 (.clk(clk), .rst(rst), .seq_if(if_or3));

    // kind 0: OR, 1: AND (wrong gate), 2: XOR with output stuck at 1 on vector 3
    function automatic logic gate_y(input int kind, input logic [2:0] v);
        case (kind)
            1:       return &v[1:0];
            2:       return (^v[1:0]) | (v[1:0] == 2'b11);
            default: return |v;
        endcase
    endfunction

    function automatic res_t model(input int n, input logic [7:0] truth, input int kind);
        res_t r;
        r = '0;
        for (int v = 0; v < (1 << n); v++) begin
            if (gate_y(kind, 3'(v)) !== truth[v]) begin
                if (r.err == 4'd0) r.ff = 3'(v);
                r.err = r.err + 4'd1;
                r.map[v] = 1'b1;
            end
        end
        r.pass = (r.err == 4'd0);
        return r;
    endfunction

    always_comb if_or.gate_out  = gate_y(kind_or, {1'b0, if_or.gate_in});
    always_comb if_xor.gate_out = gate_y(2, {1'b0, if_xor.gate_in});
    always_comb if_or3.gate_out = gate_y(0, if_or3.gate_in);

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({if_or.gate_in, if_or.busy, if_or.done, if_or.pass, if_or.err_count, if_or.first_fail} !== 10'd0) begin
            errors++;
            $display("FAIL reset_or: got gin=%0d busy=%b done=%b pass=%b err=%0d ff=%0d, want all 0",
                     if_or.gate_in, if_or.busy, if_or.done, if_or.pass, if_or.err_count, if_or.first_fail);
        end
        checks++;
        if ({if_or3.gate_in, if_or3.busy, if_or3.done, if_or3.pass, if_or3.err_count} !== 10'd0) begin
            errors++;
            $display("FAIL reset_or3: got gin=%0d busy=%b done=%b pass=%b err=%0d, want all 0",
                     if_or3.gate_in, if_or3.busy, if_or3.done, if_or3.pass, if_or3.err_count);
        end
    endtask

    // Full run on the OR2 instance; optionally pokes start at cycles 3 and 10.
    task automatic run_or(input bit poke, input string tag);
        res_t e;
        @(negedge clk) if_or.start = 1'b1;
        @(negedge clk) if_or.start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (if_or.gate_in !== 2'(k / 5) || if_or.busy !== 1'b1 || if_or.done !== 1'b0) begin
                errors++;
                $display("FAIL %s step%0d: got gin=%0d busy=%b done=%b, want gin=%0d busy=1 done=0",
                         tag, k, if_or.gate_in, if_or.busy, if_or.done, k / 5);
            end
            if_or.start = poke && (k == 2 || k == 9);
            @(negedge clk);
        end
        if_or.start = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue, want one entry", tag);
        end else begin
            e = sb.pop_front();
            if ({if_or.done, if_or.busy, if_or.pass, 4'(if_or.err_count), 3'(if_or.first_fail)} !==
                {1'b1, 1'b0, e.pass, e.err, e.ff}) begin
                errors++;
                $display("FAIL %s result: got done=%b busy=%b pass=%b err=%0d ff=%0d, want done=1 busy=0 pass=%b err=%0d ff=%0d",
                         tag, if_or.done, if_or.busy, if_or.pass, if_or.err_count, if_or.first_fail,
                         e.pass, e.err, e.ff);
            end
`ifdef GATE_TEST_SEQ_FAILMAP_EN
            checks++;
            if (if_or.fail_map !== e.map[3:0]) begin
                errors++;
                $display("FAIL %s fail_map: got %b, want %b", tag, if_or.fail_map, e.map[3:0]);
            end
`endif
        end
    endtask

    task automatic test_or_pass();
        kind_or = 0;
        sb.push_back(model(2, 8'(TT_OR2), 0));
        run_or(1'b0, "or_pass");
    endtask

    task automatic test_and_fault();
        kind_or = 1;
        sb.push_back(model(2, 8'(TT_OR2), 1));
        run_or(1'b0, "and_fault");
    endtask

    task automatic test_restart();
        res_t e;
        kind_or = 1;
        e = model(2, 8'(TT_OR2), 1);
        sb.push_back(e);
        run_or(1'b1, "ignore_start");
        for (int k = 20; k < 25; k++) begin
            checks++;
            if (if_or.done !== 1'b1 || if_or.gate_in !== 2'd3 || 4'(if_or.err_count) !== e.err) begin
                errors++;
                $display("FAIL done_hold c%0d: got done=%b gin=%0d err=%0d, want done=1 gin=3 err=%0d",
                         k, if_or.done, if_or.gate_in, if_or.err_count, e.err);
            end
            if_or.start = (k == 24);
            @(negedge clk);
        end
        if_or.start = 1'b0;
        checks++;
        if ({if_or.done, if_or.busy, if_or.err_count, if_or.first_fail, if_or.gate_in} !== {1'b0, 1'b1, 7'd0}) begin
            errors++;
            $display("FAIL restart: got done=%b busy=%b err=%0d ff=%0d gin=%0d, want done=0 busy=1 err=0 ff=0 gin=0",
                     if_or.done, if_or.busy, if_or.err_count, if_or.first_fail, if_or.gate_in);
        end
        repeat (19) @(negedge clk);
        checks++;
        if (if_or.done !== 1'b0) begin
            errors++;
            $display("FAIL restart_early: got done=%b at cycle 44, want 0", if_or.done);
        end
        @(negedge clk);
        checks++;
        if (if_or.done !== 1'b1 || 4'(if_or.err_count) !== e.err) begin
            errors++;
            $display("FAIL restart_done: got done=%b err=%0d, want done=1 err=%0d", if_or.done, if_or.err_count, e.err);
        end
    endtask

    task automatic test_reset_midrun();
        kind_or = 1;
        @(negedge clk) if_or.start = 1'b1;
        @(negedge clk) if_or.start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({if_or.gate_in, if_or.busy, if_or.done, if_or.pass, if_or.err_count, if_or.first_fail} !== 10'd0) begin
                errors++;
                $display("FAIL midrun_reset c%0d: got gin=%0d busy=%b done=%b pass=%b err=%0d ff=%0d, want all 0",
                         k, if_or.gate_in, if_or.busy, if_or.done, if_or.pass, if_or.err_count, if_or.first_fail);
            end
            @(negedge clk);
        end
        kind_or = 0;
        sb.push_back(model(2, 8'(TT_OR2), 0));
        run_or(1'b0, "after_reset");
    endtask

    task automatic test_xor_stuck();
        res_t e;
        sb.push_back(model(2, 8'(TT_XOR2), 2));
        @(negedge clk) if_xor.start = 1'b1;
        @(negedge clk) if_xor.start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (if_xor.done !== 1'b0 || if_xor.gate_in !== 2'(k / 5)) begin
                errors++;
                $display("FAIL xor step%0d: got done=%b gin=%0d, want done=0 gin=%0d", k, if_xor.done, if_xor.gate_in, k / 5);
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL xor scoreboard: got empty queue, want one entry");
        end else begin
            e = sb.pop_front();
            if ({if_xor.done, if_xor.pass, 4'(if_xor.err_count), 3'(if_xor.first_fail)} !== {1'b1, e.pass, e.err, e.ff}) begin
                errors++;
                $display("FAIL xor result: got done=%b pass=%b err=%0d ff=%0d, want done=1 pass=%b err=%0d ff=%0d",
                         if_xor.done, if_xor.pass, if_xor.err_count, if_xor.first_fail, e.pass, e.err, e.ff);
            end
`ifdef GATE_TEST_SEQ_FAILMAP_EN
            checks++;
            if (if_xor.fail_map !== e.map[3:0]) begin
                errors++;
                $display("FAIL xor fail_map: got %b, want %b", if_xor.fail_map, e.map[3:0]);
            end
`endif
        end
    endtask

    task automatic test_or3_hold1();
        res_t e;
        sb.push_back(model(3, 8'hFE, 0));
        @(negedge clk) if_or3.start = 1'b1;
        @(negedge clk) if_or3.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (if_or3.done !== 1'b0 || if_or3.gate_in !== 3'(k)) begin
                errors++;
                $display("FAIL or3 step%0d: got done=%b gin=%0d, want done=0 gin=%0d", k, if_or3.done, if_or3.gate_in, k);
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL or3 scoreboard: got empty queue, want one entry");
        end else begin
            e = sb.pop_front();
            if ({if_or3.done, if_or3.pass, 4'(if_or3.err_count), if_or3.first_fail} !== {1'b1, e.pass, e.err, e.ff}) begin
                errors++;
                $display("FAIL or3 result: got done=%b pass=%b err=%0d ff=%0d, want done=1 pass=%b err=%0d ff=%0d",
                         if_or3.done, if_or3.pass, if_or3.err_count, if_or3.first_fail, e.pass, e.err, e.ff);
            end
        end
    endtask

    initial begin
        if_or.start  = 1'b0;
        if_xor.start = 1'b0;
        if_or3.start = 1'b0;
        test_reset();
        test_or_pass();
        test_and_fault();
        test_restart();
        test_reset_midrun();
        test_xor_stuck();
        test_or3_hold1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
